// File: rtl/rrp_burst_arbiter.sv
// Round-robin burst arbiter merging FWFT source FIFOs into one output stream.
// Optional RRP_BURST_ARBITER_CH_TAG_EN: channel index in the DATA_OUT MSBs.

module rrp_burst_arbiter #(
  parameter int NCH          = 8,
  parameter int DW           = 32,
  parameter int BURST_LEN    = 4,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                    BUS_CLK,
  input  logic                    nRST,
  input  logic [NCH-1:0]          CH_ENABLE,
  input  logic [NCH-1:0]          WRITE_REQ,
  input  logic [NCH-1:0]          HOLD_REQ,
  input  logic [NCH*DW-1:0]       DATA_IN,
  output logic [NCH-1:0]          READ_GRANT,
  input  logic                    READY_OUT,
  output logic                    WRITE_OUT,
  output logic [DW-1:0]           DATA_OUT,
  output logic [$clog2(NCH)-1:0]  GRANT_CH,
  output logic                    HOLD_TIMEOUT_ERR
);

  localparam int GW = $clog2(NCH);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(HOLD_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            wout_q;
  logic [DW-1:0]   dout_q;

  logic [NCH-1:0]  req;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   scan;
  logic            found;
  logic            wreq_g;
  logic            en_g;
  logic            hold_g;
  logic            rd;
  logic            idle_tick;
  logic            timeout;
  logic            rel;
  logic [DW-1:0]   sel_word;
  logic [DW-1:0]   word_d;

  assign req = WRITE_REQ & CH_ENABLE;

  // first requester strictly after last_served, wrapping
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    scan  = '0;
    for (int k = 1; k <= NCH; k++) begin
      scan = GW'((int'(last_q) + k) % NCH);
      if (!found && req[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  assign wreq_g = WRITE_REQ[grant_q];
  assign en_g   = CH_ENABLE[grant_q];
  assign hold_g = HOLD_REQ[grant_q];

  assign rd = (state_q == BURST) & wreq_g & READY_OUT & en_g;

  // a stalled cycle (READY_OUT low) never counts toward the timeout
  assign idle_tick = (state_q == BURST) & hold_g & READY_OUT & ~rd;
  assign timeout   = idle_tick & en_g & (idle_q == IDLE_LAST);

  assign rel = !en_g
             || (rd && (burst_q == BURST_LAST) && !hold_g)
             || (!wreq_g && !hold_g)
             || timeout;

  assign READ_GRANT = rd
    ? ({{(NCH-1){1'b0}}, 1'b1} << grant_q)
    : '0;
  assign HOLD_TIMEOUT_ERR = timeout;

  assign sel_word = DATA_IN[int'(grant_q)*DW +: DW];

`ifdef RRP_BURST_ARBITER_CH_TAG_EN
  assign word_d = {grant_q, sel_word[DW-GW-1:0]};
`else
  assign word_d = sel_word;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BURST;
          grant_d = pick;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      BURST: begin
        unique case (1'b1)
          rd: begin
            idle_d = '0;
            if (burst_q != BURST_LAST)
              burst_d = burst_q + 1'b1;
          end
          idle_tick: begin
            if (idle_q != IDLE_LAST)
              idle_d = idle_q + 1'b1;
          end
          default: ;
        endcase
        if (rel) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NCH - 1);
      burst_q <= '0;
      idle_q  <= '0;
      wout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      wout_q  <= rd;
      if (rd)
        dout_q <= word_d;
    end
  end

  assign WRITE_OUT = wout_q;
  assign DATA_OUT  = dout_q;
  assign GRANT_CH  = grant_q;

endmodule

// File: tb/tb_rrp_burst_arbiter.sv
// Bench for rrp_burst_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.

module tb_rrp_burst_arbiter;

  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int BL  = 4;
  localparam int TO  = 10;

  typedef logic [DW-1:0] word_t;

  logic              BUS_CLK = 1'b0;
  logic              nRST = 1'b1;
  logic [NCH-1:0]    CH_ENABLE = '0;
  logic [NCH-1:0]    WRITE_REQ = '0;
  logic [NCH-1:0]    HOLD_REQ = '0;
  logic [NCH*DW-1:0] DATA_IN = '0;
  logic [NCH-1:0]    READ_GRANT;
  logic              READY_OUT = 1'b0;
  logic              WRITE_OUT;
  logic [DW-1:0]     DATA_OUT;
  logic [2:0]        GRANT_CH;
  logic              HOLD_TIMEOUT_ERR;

  rrp_burst_arbiter #(
    .NCH(NCH), .DW(DW), .BURST_LEN(BL), .HOLD_TIMEOUT(TO)
  ) dut (
    .BUS_CLK(BUS_CLK),
    .nRST(nRST),
    .CH_ENABLE(CH_ENABLE),
    .WRITE_REQ(WRITE_REQ),
    .HOLD_REQ(HOLD_REQ),
    .DATA_IN(DATA_IN),
    .READ_GRANT(READ_GRANT),
    .READY_OUT(READY_OUT),
    .WRITE_OUT(WRITE_OUT),
    .DATA_OUT(DATA_OUT),
    .GRANT_CH(GRANT_CH),
    .HOLD_TIMEOUT_ERR(HOLD_TIMEOUT_ERR)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // source FIFOs and their drive controls
  word_t fifo[NCH][$];
  bit    en_b[NCH];
  bit    gate_b[NCH];
  bit    hold_b[NCH];
  int    hold_lim[NCH];
  int    pop_cnt[NCH];
  bit    ready_b;

  // observations of the DUT
  int    obs_rd[NCH];
  int    rd_cyc[NCH];
  int    obs_err;
  int    err_cyc;
  int    rd_log[$];
  word_t stream[$];
  int    cur_run;
  int    max_run;

  // reference model: owner<0 means arbitrating
  int    owner, words, idle_run, last;
  bit    exp_wout;
  word_t exp_dout;
  int    exp_gch;
  logic [NCH-1:0] exp_rg;
  bit    exp_err;
  int    nx_owner, nx_words, nx_idle, nx_last, nx_gch;
  bit    nx_wout;
  word_t nx_dout;
  int    pop_ch;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic word_t sw(input int i);
    return (stream.size() > i) ? stream[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int rl(input int i);
    return (rd_log.size() > i) ? rd_log[i] : -1;
  endfunction

  task automatic model_reset();
    owner = -1; words = 0; idle_run = 0; last = NCH - 1;
    exp_wout = 0; exp_dout = '0; exp_gch = 0;
    nx_owner = -1; nx_words = 0; nx_idle = 0; nx_last = NCH - 1;
    nx_gch = 0; nx_wout = 0; nx_dout = '0; pop_ch = -1;
  endtask

  task automatic model_apply();
    owner = nx_owner; words = nx_words; idle_run = nx_idle;
    last = nx_last; exp_gch = nx_gch;
    exp_wout = nx_wout; exp_dout = nx_dout;
    if (pop_ch >= 0 && fifo[pop_ch].size() > 0) begin
      void'(fifo[pop_ch].pop_front());
      pop_cnt[pop_ch]++;
    end
  endtask

  task automatic model_eval();
    int pick, g;
    bit rd, rel, wr, en, hd;
    exp_rg = '0; exp_err = 0;
    nx_owner = owner; nx_words = words; nx_idle = idle_run;
    nx_last = last; nx_gch = exp_gch;
    nx_wout = 0; nx_dout = exp_dout; pop_ch = -1;
    if (owner < 0) begin
      pick = -1;
      for (int k = 1; k <= NCH; k++) begin
        int c = (last + k) % NCH;
        if (pick < 0 && WRITE_REQ[c] && CH_ENABLE[c]) pick = c;
      end
      if (pick >= 0) begin
        nx_owner = pick; nx_gch = pick;
        nx_words = 0; nx_idle = 0;
      end
    end else begin
      g = owner;
      wr = WRITE_REQ[g]; en = CH_ENABLE[g]; hd = HOLD_REQ[g];
      rd = wr && en && READY_OUT;
      if (rd) begin
        exp_rg[g] = 1'b1; pop_ch = g;
        nx_wout = 1; nx_dout = fifo[g][0];
        nx_words = words + 1; nx_idle = 0;
      end else if (hd && READY_OUT) begin
        nx_idle = idle_run + 1;
      end
      rel = !en || (rd && words + 1 >= BL && !hd) || (!wr && !hd);
      if (!rel && hd && READY_OUT && !rd && idle_run + 1 >= TO) begin
        rel = 1; exp_err = 1;
      end
      if (rel) begin
        nx_owner = -1; nx_last = g;
      end
    end
  endtask

  task automatic drive();
    bit w;
    for (int i = 0; i < NCH; i++) begin
      w = gate_b[i] && (fifo[i].size() > 0);
      WRITE_REQ[i] = w;
      CH_ENABLE[i] = en_b[i];
      HOLD_REQ[i]  = hold_b[i] && (pop_cnt[i] < hold_lim[i]);
      DATA_IN[i*DW +: DW] = w ? fifo[i][0] : (32'hDEAD_0000 | i);
    end
    READY_OUT = ready_b;
  endtask

  task automatic compare();
    check("read_grant", 32'(READ_GRANT), 32'(exp_rg));
    check("timeout_err", 32'(HOLD_TIMEOUT_ERR), 32'(exp_err));
    check("write_out", 32'(WRITE_OUT), 32'(exp_wout));
    check("grant_ch", 32'(GRANT_CH), exp_gch);
    if (exp_wout) check("data_out", DATA_OUT, exp_dout);
    for (int i = 0; i < NCH; i++) begin
      if (READ_GRANT[i]) begin
        obs_rd[i]++; rd_cyc[i] = cyc; rd_log.push_back(i);
      end
    end
    if (HOLD_TIMEOUT_ERR) begin
      obs_err++; err_cyc = cyc;
    end
    if (WRITE_OUT) begin
      stream.push_back(DATA_OUT);
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
  endtask

  task automatic step();
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    model_apply();
    drive();
    #1;
    model_eval();
    compare();
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NCH; i++) begin
      obs_rd[i] = 0; rd_cyc[i] = -1; pop_cnt[i] = 0;
    end
    obs_err = 0; err_cyc = -1;
    rd_log.delete(); stream.delete();
    cur_run = 0; max_run = 0;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < NCH; i++) begin
      fifo[i].delete();
      en_b[i] = 1; gate_b[i] = 1; hold_b[i] = 0;
      hold_lim[i] = 1 << 30;
    end
    ready_b = 1;
    clear_obs();
  endtask

  task automatic reset_assert();
    nRST = 1'b0;
    #1;
    check("rst_read_grant", 32'(READ_GRANT), 0);
    check("rst_write_out", 32'(WRITE_OUT), 0);
    check("rst_data_out", DATA_OUT, 0);
    check("rst_grant_ch", 32'(GRANT_CH), 0);
    check("rst_timeout_err", 32'(HOLD_TIMEOUT_ERR), 0);
    model_reset();
  endtask

  task automatic reset_release();
    repeat (2) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    nRST = 1'b1;
    drive();
    #1;
    model_eval();
    compare();
    cyc++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, guard;
    word_t seq;
    seq = 0;
    clear_bench();
    #2;

    // 1: all channels, 10 words each, round-robin bursts of 4
    reset_assert();
    clear_bench();
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < 10; k++)
        fifo[ch].push_back(32'hA000_0000 | (ch << 8) | k);
    reset_release();
    guard = 0;
    while (stream.size() < 80 && guard < 400) begin
      step(); guard++;
    end
    run(5);
    check("s1_words", stream.size(), 80);
    check("s1_first", sw(0), 32'hA000_0000);
    check("s1_ch1", sw(4), 32'hA000_0100);
    check("s1_round2", sw(32), 32'hA000_0004);
    check("s1_last", sw(79), 32'hA000_0709);

    // 2: hold stretches one grant past the burst limit
    reset_assert();
    clear_bench();
    for (int k = 0; k < 7; k++)
      fifo[3].push_back(32'hB000_0300 | k);
    hold_b[3] = 1; hold_lim[3] = 6;
    reset_release();
    run(30);
    check("s2_words", stream.size(), 7);
    check("s2_contiguous", max_run, 7);
    check("s2_last", sw(6), 32'hB000_0306);

    // 3: hold timeout after one word, then ch5
    reset_assert();
    clear_bench();
    fifo[2].push_back(32'hC000_0200);
    for (int k = 0; k < 3; k++)
      fifo[5].push_back(32'hC000_0500 | k);
    hold_b[2] = 1;
    reset_release();
    guard = 0;
    while (obs_err == 0 && guard < 60) begin
      step(); guard++;
    end
    run(12);
    check("s3_err_count", obs_err, 1);
    check("s3_err_delay", err_cyc - rd_cyc[2], 10);
    check("s3_next_ch", rl(1), 5);
    check("s3_ch5_words", obs_rd[5], 3);

    // 4: backpressure never counts as idle
    reset_assert();
    clear_bench();
    for (int k = 0; k < 40; k++)
      fifo[0].push_back(32'hE000_0000 | k);
    hold_b[0] = 1;
    reset_release();
    repeat (40) begin
      ready_b = !ready_b;
      step();
    end
    ready_b = 0;
    run(300);
    check("s4_no_timeout", obs_err, 0);
    check("s4_stalled_pending", 32'(obs_rd[0] < 40), 1);
    ready_b = 1; hold_b[0] = 0;
    run(80);
    check("s4_all_read", obs_rd[0], 40);
    check("s4_last", sw(39), 32'hE000_0027);

    // 5: disable ch1 mid-burst
    reset_assert();
    clear_bench();
    for (int k = 0; k < 8; k++) begin
      fifo[1].push_back(32'hF000_0100 | k);
      fifo[2].push_back(32'hF000_0200 | k);
    end
    reset_release();
    guard = 0;
    while (obs_rd[1] < 2 && guard < 20) begin
      step(); guard++;
    end
    en_b[1] = 0;
    run(40);
    check("s5_ch1_reads", obs_rd[1], 2);
    check("s5_next_ch", rl(2), 2);
    check("s5_ch2_reads", obs_rd[2], 8);

    // 6: reset in the middle of a burst
    reset_assert();
    clear_bench();
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < 6; k++)
        fifo[ch].push_back(32'h9000_0000 | (ch << 8) | k);
    reset_release();
    guard = 0;
    while (obs_rd[0] < 2 && guard < 20) begin
      step(); guard++;
    end
    check("s6_pre_wout", 32'(WRITE_OUT), 1);
    reset_assert();
    clear_obs();
    reset_release();
    run(10);
    check("s6_first_ch", rl(0), 0);

    // random traffic
    reset_assert();
    clear_bench();
    reset_release();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, NCH - 1);
        if (fifo[c].size() < 12) begin
          fifo[c].push_back(32'h5000_0000 | (c << 20) | seq[19:0]);
          seq++;
        end
      end
      c = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 40) == 0) en_b[c] = !en_b[c];
      gate_b[c] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 12) == 0) hold_b[c] = !hold_b[c];
      ready_b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) begin
        reset_assert();
        reset_release();
      end else begin
        step();
      end
    end
    for (int i = 0; i < NCH; i++) begin
      en_b[i] = 1; gate_b[i] = 1; hold_b[i] = 0;
    end
    ready_b = 1;
    run(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rrp_burst_arbiter.md
Name: rrp_burst_arbiter

Overview:
Parametrised successor to the single-word round-robin FIFO arbiter that merges data-source FIFOs into the single 32-bit output stream of the readout core. Adds:
- generic channel count
- per-channel enable mask
- burst grants of up to BURST_LEN words per channel
- packet hold with timeout, so multi-word records (timestamp pairs, TLU words) stay contiguous

Sits between the per-source first-word-fall-through FIFOs and the SiTCP/USB output FIFO, all in the BUS_CLK domain.

Parameters:
NCH, 8, number of input channels (2..32); channel 0 has the lowest index
DW, 32, data word width
BURST_LEN, 4, max words read from one channel per grant (1..256)
HOLD_TIMEOUT, 255, max consecutive idle cycles a held grant waits before release (1..65535)

Ports:
BUS_CLK  in  1  clock, all logic on rising edge
nRST  in  1  asynchronous active-low reset
CH_ENABLE  in  NCH  per-channel enable mask; disabled channels are never granted
WRITE_REQ  in  NCH  per-channel request (= ~FIFO_EMPTY)
HOLD_REQ  in  NCH  per-channel packet-in-progress; keeps grant while asserted
DATA_IN  in  NCH*DW  channel data, channel i at bits [i*DW +: DW]; valid while WRITE_REQ[i]
READ_GRANT  out  NCH  one-hot FIFO read strobe, combinational
READY_OUT  in  1  downstream can accept a word this cycle
WRITE_OUT  out  1  registered write strobe to downstream
DATA_OUT  out  DW  registered data
GRANT_CH  out  clog2(NCH)  index of the channel currently owning the bus
HOLD_TIMEOUT_ERR  out  1  one-cycle pulse when a hold is broken by timeout

Behaviour:
Reset (nRST low, asynchronous):
- READ_GRANT=0, WRITE_OUT=0, DATA_OUT=0, GRANT_CH=0, HOLD_TIMEOUT_ERR=0
- state=IDLE, last_served=NCH-1, burst_cnt=0, idle_cnt=0

State machine, two states IDLE and BURST.

IDLE:
- req = WRITE_REQ & CH_ENABLE.
- If req!=0, choose the first set bit scanning upward from last_served+1, wrapping modulo NCH.
- Next cycle: GRANT_CH=chosen, burst_cnt=0, idle_cnt=0, state=BURST. No read happens in IDLE, so arbitration costs 1 cycle.

BURST, with g=GRANT_CH:
- READ_GRANT[g] = WRITE_REQ[g] & READY_OUT & CH_ENABLE[g]; all other bits 0.
- On a read:
  - DATA_OUT <= DATA_IN[g], WRITE_OUT <= 1 next cycle (latency 1).
  - burst_cnt++, idle_cnt=0.
- Otherwise WRITE_OUT <= 0 next cycle.
- Exit to IDLE with last_served=g, checked in priority order:
  a. CH_ENABLE[g]==0: immediate; no read this cycle.
  b. Read occurs with burst_cnt==BURST_LEN-1 and HOLD_REQ[g]==0.
  c. WRITE_REQ[g]==0 and HOLD_REQ[g]==0.
  d. HOLD_REQ[g]==1 with no read while idle_cnt==HOLD_TIMEOUT-1: HOLD_TIMEOUT_ERR pulses for 1 cycle.
- If no read occurs while HOLD_REQ[g]==1, idle_cnt++ (saturating).
- HOLD_REQ[g]==1 overrides the burst limit: burst_cnt saturates at BURST_LEN-1 and the grant continues until hold drops or times out.
- READY_OUT low stalls the grant but is not an idle cycle for timeout purposes (idle_cnt unchanged); backpressure never breaks a hold.

Fairness and boundaries:
- A channel re-requesting after release is served only after all other requesting enabled channels have had one grant.
- NCH=1 degenerates to continuous service with 1 idle cycle between bursts.
- Simultaneous WRITE_REQ rising and CH_ENABLE falling on a channel: not granted.
- nRST assertion mid-burst drops WRITE_OUT asynchronously; a word read but not yet written is lost by design.

Optional Feature:
Macro RRP_BURST_ARBITER_CH_TAG_EN.
- Defined: DATA_OUT[DW-1 -: clog2(NCH)] is replaced by the granted channel index on every word, for debugging of unidentified sources; lower bits pass through.
- Undefined: DATA_OUT is the exact DATA_IN word and no tag logic is synthesised.

Test Plan:
1. NCH=8, BURST_LEN=4, all enabled, every FIFO holding 10 words, READY_OUT=1 -> output order is ch0×4, ch1×4 … ch7×4, ch0×4 …; one WRITE_OUT=0 gap between bursts; 80 words total, no loss or duplication.
2. Only ch3 requesting, HOLD_REQ[3] high for 7 words with BURST_LEN=4 -> 7 contiguous ch3 words in one grant, then IDLE.
3. Hold timeout: ch2 with HOLD_REQ=1, WRITE_REQ drops after 1 word, HOLD_TIMEOUT=10 -> HOLD_TIMEOUT_ERR pulses exactly 10 cycles after the last read; ch5 then granted.
4. Backpressure: READY_OUT toggling 1-0-1-0 during a burst -> READ_GRANT only when READY_OUT=1; data order preserved; no timeout even with 300 stalled cycles.
5. Disable ch1 mid-burst after 2 words -> grant released immediately, READ_GRANT[1] never asserts again; ch2 served next.
6. Assert nRST during a burst -> all outputs 0 immediately; after release, ch0 is granted first if requesting.
